// File: rtl/div_pkg.sv
// div_pkg: FSM state type and sign/width helpers shared by the handshaked restoring divider.
package div_pkg;
  localparam int MAXW = 64;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
  // value is expected sign-extended to MAXW so its sign sits in the top bit
  function automatic logic [MAXW-1:0] abs_val(input logic [MAXW-1:0] value, input logic is_signed);
    return (is_signed && value[MAXW-1]) ? -value : value;
  endfunction
  function automatic logic [MAXW-1:0] cond_neg(input logic [MAXW-1:0] value, input logic neg);
    return neg ? -value : value;
  endfunction
endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step: one combinational restoring-division iteration on {R,Q} against D.
module restoring_div_step #(
  parameter int W = 16
) (
  input  logic [W:0]   r,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W:0]   r_nxt,
  output logic [W-1:0] q_nxt
);
  logic [W:0] sh, t;
  logic unused_msb;
  assign unused_msb = r[W];
  assign sh = {r[W-1:0], q[W-1]};
  assign t = sh - {1'b0, d};
  assign r_nxt = t[W] ? sh : t;
  assign q_nxt = {q[W-2:0], ~t[W]};
endmodule

// File: rtl/restoring_divider_hs.sv
// restoring_divider_hs: valid/ready sequential restoring divider, one quotient bit per cycle,
// optional two's-complement mode and divide-by-zero flag.
module restoring_divider_hs
  import div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             valid_in,
  output logic             ready_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  localparam int PW = MAXW - WIDTH;
  state_t state;
  logic [WIDTH:0] r, r_step;
  logic [WIDTH-1:0] q, d, q_step, dvd_abs, dvs_abs, quo_fin, rem_fin;
  logic [CW-1:0] cnt;
  logic q_neg, r_neg, dbz, sgn;
  logic [PW-1:0] unused_a, unused_b, unused_c, unused_d;
  assign sgn = (SIGNED_EN != 0) && is_signed;
  assign {unused_a, dvd_abs} = abs_val({{PW{dividend[WIDTH-1]}}, dividend}, sgn);
  assign {unused_b, dvs_abs} = abs_val({{PW{divisor[WIDTH-1]}}, divisor}, sgn);
  assign {unused_c, quo_fin} = cond_neg({{PW{1'b0}}, q}, q_neg);
  assign {unused_d, rem_fin} = cond_neg({{PW{1'b0}}, r[WIDTH-1:0]}, r_neg);
  restoring_div_step #(.W(WIDTH)) u_step (
    .r(r),
    .q(q),
    .d(d),
    .r_nxt(r_step),
    .q_nxt(q_step)
  );
  // a zero divisor skips CALC: Q/R are preloaded with the all-ones quotient and raw dividend
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dbz <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      valid_out <= 1'b0;
      busy <= 1'b0;
      ready_in <= 1'b1;
    end else
      case (state)
        IDLE:
          if (valid_in) begin
            ready_in <= 1'b0;
            busy <= 1'b1;
            dbz <= divisor == '0;
            d <= dvs_abs;
            cnt <= CW'(WIDTH);
            q <= divisor == '0 ? '1 : dvd_abs;
            r <= divisor == '0 ? {1'b0, dividend} : '0;
            q_neg <= divisor != '0 && sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= divisor != '0 && sgn && dividend[WIDTH-1];
            state <= divisor == '0 ? DONE : CALC;
          end
        CALC: begin
          r <= r_step;
          q <= q_step;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE:
          if (!valid_out) begin
            quotient <= quo_fin;
            remainder <= rem_fin;
            div_by_zero <= dbz;
            valid_out <= 1'b1;
          end else if (ready_out) begin
            valid_out <= 1'b0;
            busy <= 1'b0;
            ready_in <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_restoring_divider_hs.sv
// tb_restoring_divider_hs: randomized and directed checks against an arithmetic reference model.
module tb_restoring_divider_hs;
  localparam int W = 8;
  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dbz;
  } res_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0, quotient, remainder;
  logic is_signed = 1'b0, valid_in = 1'b0, ready_out = 1'b1;
  logic ready_in, valid_out, div_by_zero, busy;
  int checks = 0, passes = 0;
  bit m_idle = 1'b1;
  int e = 0, due = 0;
  res_t cur = '0;
  restoring_divider_hs #(.WIDTH(W), .SIGNED_EN(1)) dut (
    .clk(clk),
    .reset(reset),
    .dividend(dividend),
    .divisor(divisor),
    .is_signed(is_signed),
    .valid_in(valid_in),
    .ready_in(ready_in),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t o;
    int sa, sb;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    if (b == '0) o = '{q: '1, r: a, dbz: 1'b1};
    else o = '{q: W'(sa / sb), r: W'(sa % sb), dbz: 1'b0};
    return o;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // cycle-level model: result appears lat edges after acceptance, held until consumed
  always @(posedge clk or negedge reset)
    if (!reset) m_idle = 1'b1;
    else begin
      e++;
      if (!m_idle && e > due && ready_out) m_idle = 1'b1;
      else if (m_idle && valid_in) begin
        cur = ref_div(dividend, divisor, is_signed);
        due = e + (divisor == '0 ? 1 : W + 1);
        m_idle = 1'b0;
      end
    end
  always @(negedge clk)
    if (reset) begin
      check("ready_in", 32'(ready_in), 32'(m_idle));
      check("busy", 32'(busy), 32'(!m_idle));
      check("valid_out", 32'(valid_out), 32'(!m_idle && e >= due));
      if (!m_idle && e >= due) begin
        check("quotient", 32'(quotient), 32'(cur.q));
        check("remainder", 32'(remainder), 32'(cur.r));
        check("div_by_zero", 32'(div_by_zero), 32'(cur.dbz));
      end
    end
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int bp);
    int n;
    @(negedge clk);
    dividend = a;
    divisor = b;
    is_signed = s;
    valid_in = 1'b1;
    ready_out = bp == 0;
    @(negedge clk);
    valid_in = 1'b0;
    n = 0;
    while (!valid_out && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!valid_out) check("result_timeout", 32'(valid_out), 32'd1);
    for (int i = 0; i < bp; i++) begin
      dividend = W'($urandom);
      divisor = W'($urandom);
      is_signed = 1'($urandom);
      valid_in = 1'b1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    check("model_200_7", 32'(ref_div(8'd200, 8'd7, 1'b0)), 32'({8'd28, 8'd4, 1'b0}));
    check("model_m7_2", 32'(ref_div(8'hF9, 8'd2, 1'b1)), 32'({8'hFD, 8'hFF, 1'b0}));
    check("model_7_m2", 32'(ref_div(8'd7, 8'hFE, 1'b1)), 32'({8'hFD, 8'h01, 1'b0}));
    check("model_45_0u", 32'(ref_div(8'd45, 8'd0, 1'b0)), 32'({8'hFF, 8'd45, 1'b1}));
    check("model_45_0s", 32'(ref_div(8'd45, 8'd0, 1'b1)), 32'({8'hFF, 8'd45, 1'b1}));
    check("model_ovf_s", 32'(ref_div(8'h80, 8'hFF, 1'b1)), 32'({8'h80, 8'h00, 1'b0}));
    check("model_ovf_u", 32'(ref_div(8'h80, 8'hFF, 1'b0)), 32'({8'h00, 8'd128, 1'b0}));
    check("model_100_9", 32'(ref_div(8'd100, 8'd9, 1'b0)), 32'({8'd11, 8'd1, 1'b0}));
    #1;
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run(8'd200, 8'd7, 1'b0, 0);
    run(8'hF9, 8'd2, 1'b1, 0);
    run(8'd7, 8'hFE, 1'b1, 0);
    run(8'd45, 8'd0, 1'b0, 0);
    run(8'd45, 8'd0, 1'b1, 0);
    run(8'h80, 8'hFF, 1'b1, 0);
    run(8'h80, 8'hFF, 1'b0, 0);
    run(8'd200, 8'd7, 1'b0, 5);
    run(8'hF9, 8'd2, 1'b1, 0);
    @(negedge clk);
    dividend = 8'd250;
    divisor = 8'd3;
    is_signed = 1'b0;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_valid_out", 32'(valid_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready_in", 32'(ready_in), 32'd1);
    run(8'd100, 8'd9, 1'b0, 0);
    for (int i = 0; i < 150; i++)
      run(W'($urandom), ($urandom_range(0, 9) == 0) ? 8'd0 : W'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
